// File: rtl/signal_generator_multiwave.sv
// Phase-accumulator tone generator (square/saw/triangle) with a valid/ready config slot.
// Define SIGGEN_NOISE_MODE_EN to turn mode 3 into LFSR sample-and-hold noise.
module signal_generator_multiwave #(
    parameter int SAMPLE_RATE  = 32000,
    parameter int FREQ_WIDTH   = 14,
    parameter int SAMPLE_WIDTH = 8,
    parameter int ACC_WIDTH    = 16
) (
    input  logic                    CLK_32KHz,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [FREQ_WIDTH-1:0]   cfg_freq,
    input  logic [1:0]              cfg_mode,
    input  logic [SAMPLE_WIDTH-1:0] cfg_duty,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic                    index_zero
);
    localparam int PW = ACC_WIDTH + SAMPLE_WIDTH;
    localparam logic [31:0]             HALF_RATE = 32'(SAMPLE_RATE / 2);
    localparam logic [ACC_WIDTH:0]      RATE_S    = (ACC_WIDTH+1)'(SAMPLE_RATE);
    localparam logic [PW-1:0]           RATE_P    = PW'(SAMPLE_RATE);
    localparam logic [SAMPLE_WIDTH-1:0] FULL      = '1;
    localparam logic [SAMPLE_WIDTH-1:0] DUTY_RST  = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    function automatic logic [FREQ_WIDTH-1:0] clamp_freq(input logic [FREQ_WIDTH-1:0] f);
        if (32'(f) > HALF_RATE) return FREQ_WIDTH'(HALF_RATE);
        return f;
    endfunction

    function automatic logic [SAMPLE_WIDTH-1:0] phase_index(input logic [ACC_WIDTH-1:0] a);
        logic [PW-1:0] scaled;
        scaled = {a, {SAMPLE_WIDTH{1'b0}}};
        return SAMPLE_WIDTH'(scaled / RATE_P);
    endfunction

    function automatic logic [SAMPLE_WIDTH-1:0] wave(input logic [1:0]              mode,
                                                     input logic [SAMPLE_WIDTH-1:0] duty,
                                                     input logic [SAMPLE_WIDTH-1:0] idx);
        logic [SAMPLE_WIDTH-1:0] fold;
        fold = idx[SAMPLE_WIDTH-1] ? ~idx : idx;
        case (mode)
            2'd0:    wave = (idx < duty) ? FULL : '0;
            2'd1:    wave = idx;
            2'd2:    wave = fold << 1;
            default: wave = '0;
        endcase
    endfunction

`ifdef SIGGEN_NOISE_MODE_EN
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
`endif

    logic [ACC_WIDTH-1:0]    acc;
    logic [ACC_WIDTH-1:0]    acc_next;
    logic [ACC_WIDTH:0]      sum;
    logic                    wrap;
    logic                    apply;
    logic                    take;
    logic                    pend;
    logic [FREQ_WIDTH-1:0]   freq_act, freq_pend, freq_next;
    logic [1:0]              mode_act, mode_pend, mode_next;
    logic [SAMPLE_WIDTH-1:0] duty_act, duty_pend, duty_next;
    logic [SAMPLE_WIDTH-1:0] sample_next;

    assign cfg_ready = !pend && !reset;
    assign take      = cfg_valid && cfg_ready;

`ifdef SIGGEN_NOISE_MODE_EN
    assign lfsr_next = wrap ? lfsr_step(lfsr) : lfsr;
`endif

    // Next-state: accumulator step, wrap detection and config hand-over
    always_comb begin
        sum       = {1'b0, acc} + (ACC_WIDTH+1)'(freq_act);
        wrap      = enable && (sum >= RATE_S);
        // An idle or stopped generator has no phase to preserve, so it retunes at once.
        apply     = pend && (wrap || freq_act == '0 || !enable);
        freq_next = apply ? freq_pend : freq_act;
        mode_next = apply ? mode_pend : mode_act;
        duty_next = apply ? duty_pend : duty_act;

        if (!enable || (apply && !wrap)) acc_next = '0;
        else if (wrap)                   acc_next = ACC_WIDTH'(sum - RATE_S);
        else                             acc_next = sum[ACC_WIDTH-1:0];

        if (!enable)                     sample_next = '0;
`ifdef SIGGEN_NOISE_MODE_EN
        else if (mode_next == 2'd3)      sample_next = wrap ? lfsr_next[15 -: SAMPLE_WIDTH] : sample_out;
`endif
        else                             sample_next = wave(mode_next, duty_next, phase_index(acc_next));
    end

    // Registered state; sample_out is derived from the value written into acc
    always_ff @(posedge CLK_32KHz) begin
        if (reset) begin
            acc        <= '0;
            sample_out <= '0;
            index_zero <= 1'b0;
            freq_act   <= '0;
            mode_act   <= 2'd0;
            duty_act   <= DUTY_RST;
            pend       <= 1'b0;
`ifdef SIGGEN_NOISE_MODE_EN
            lfsr       <= 16'hACE1;
`endif
        end else begin
            acc        <= acc_next;
            sample_out <= sample_next;
            index_zero <= wrap;
            freq_act   <= freq_next;
            mode_act   <= mode_next;
            duty_act   <= duty_next;
`ifdef SIGGEN_NOISE_MODE_EN
            lfsr       <= lfsr_next;
`endif
            if (apply)     pend <= 1'b0;
            else if (take) pend <= 1'b1;
        end
    end

    always_ff @(posedge CLK_32KHz) begin
        if (take) begin
            freq_pend <= clamp_freq(cfg_freq);
            mode_pend <= cfg_mode;
            duty_pend <= cfg_duty;
        end
    end

endmodule
